// File: rtl/regwb.sv
// Writeback buffer: an in-order FIFO of pending {dst, data} register writes,
// fed by a load port and an ALU port and drained into the register file.
// Optional bypass snooping of ra1/ra2 is compiled in when REGWB_BYPASS_EN is defined.
module regwb #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ld_valid,
    input  logic [4:0]  ld_dst,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_dst,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        drain_en,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        fwd1_hit,
    output logic [31:0] fwd1_data,
    output logic        fwd2_hit,
    output logic [31:0] fwd2_data,
    output logic        empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    dst_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic          ld_push;
    logic          alu_push;
    logic [PW-1:0] alu_slot;
    logic [1:0]    push_n;

    // Credit comes only from registered occupancy, so a drain this cycle
    // cannot be spent by a request arriving in the same cycle.
    assign free      = CW'(DEPTH) - count;
    assign ld_ready  = (free != '0);
    assign alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !ld_valid);

    // Writes to r0 complete the handshake but never occupy a slot.
    assign ld_push  = ld_valid && ld_ready && (ld_dst != 5'd0);
    assign alu_push = alu_valid && alu_ready && (alu_dst != 5'd0);
    assign alu_slot = ld_push ? tail + PW'(1) : tail;
    assign push_n   = {1'b0, ld_push} + {1'b0, alu_push};

    assign empty = (count == '0);
    assign we3   = !empty && drain_en;
    assign wa3   = empty ? 5'd0  : dst_q[head];
    assign wd3   = empty ? 32'd0 : data_q[head];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PW'(push_n);
            count <= count + CW'(push_n) - CW'(we3);
            if (we3) begin
                head <= head + PW'(1);
            end
        end
    end

    // Payload storage needs no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (ld_push) begin
            dst_q[tail]  <= ld_dst;
            data_q[tail] <= ld_data;
        end
        if (alu_push) begin
            dst_q[alu_slot]  <= alu_dst;
            data_q[alu_slot] <= alu_data;
        end
    end

`ifdef REGWB_BYPASS_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd1_hit  = 1'b0;
        fwd1_data = 32'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 32'd0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count) begin
                if ((ra1 != 5'd0) && (dst_q[idx] == ra1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = data_q[idx];
                end
                if ((ra2 != 5'd0) && (dst_q[idx] == ra2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = data_q[idx];
                end
            end
        end
    end
`else
    logic unused_ra;

    assign unused_ra = ^{ra1, ra2};
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = 32'd0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = 32'd0;
`endif

endmodule

// File: tb/tb_regwb.sv
// Directed, table-driven bench for regwb (DEPTH=4), with hand-written
// sequences for mid-cycle asynchronous reset; expects zero bypass outputs unless REGWB_BYPASS_EN.
module tb_regwb;

    logic        clk;
    logic        reset_n;
    logic        ld_valid;
    logic [4:0]  ld_dst;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        alu_valid;
    logic [4:0]  alu_dst;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        drain_en;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;
    logic        empty;

    int n_vec;
    int n_checks;
    int n_fail;

    typedef struct {
        logic        ldv;
        logic [4:0]  ldd;
        logic [31:0] ldx;
        logic        av;
        logic [4:0]  ad;
        logic [31:0] ax;
        logic        dr;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ldr;
        logic        e_alr;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_empty;
        logic        e_h1;
        logic [31:0] e_d1;
        logic        e_h2;
        logic [31:0] e_d2;
    } vec_t;

    vec_t vecs[$];
    vec_t rvecs[$];

    regwb #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ld_valid  (ld_valid),
        .ld_dst    (ld_dst),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .alu_valid (alu_valid),
        .alu_dst   (alu_dst),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .drain_en  (drain_en),
        .we3       (we3),
        .wa3       (wa3),
        .wd3       (wd3),
        .ra1       (ra1),
        .ra2       (ra2),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic ldv, input logic [4:0] ldd, input logic [31:0] ldx,
        input logic av, input logic [4:0] ad, input logic [31:0] ax,
        input logic dr, input logic [4:0] r1, input logic [4:0] r2,
        input logic e_ldr, input logic e_alr, input logic e_we,
        input logic [4:0] e_wa, input logic [31:0] e_wd, input logic e_empty,
        input logic e_h1, input logic [31:0] e_d1,
        input logic e_h2, input logic [31:0] e_d2);
        vec_t v;
        v.ldv = ldv; v.ldd = ldd; v.ldx = ldx;
        v.av = av; v.ad = ad; v.ax = ax;
        v.dr = dr; v.r1 = r1; v.r2 = r2;
        v.e_ldr = e_ldr; v.e_alr = e_alr; v.e_we = e_we;
        v.e_wa = e_wa; v.e_wd = e_wd; v.e_empty = e_empty;
        v.e_h1 = e_h1; v.e_d1 = e_d1; v.e_h2 = e_h2; v.e_d2 = e_d2;
        return v;
    endfunction

    task automatic cmp(input string tag, input int id, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s%0d %s: got 0x%0h, expected 0x%0h", tag, id, name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        ld_valid  = v.ldv;
        ld_dst    = v.ldd;
        ld_data   = v.ldx;
        alu_valid = v.av;
        alu_dst   = v.ad;
        alu_data  = v.ax;
        drain_en  = v.dr;
        ra1       = v.r1;
        ra2       = v.r2;
    endtask

    task automatic checkOutput(input vec_t v, input string tag, input int id);
        logic        h1;
        logic        h2;
        logic [31:0] d1;
        logic [31:0] d2;
`ifdef REGWB_BYPASS_EN
        h1 = v.e_h1; d1 = v.e_d1; h2 = v.e_h2; d2 = v.e_d2;
`else
        h1 = 1'b0; d1 = 32'd0; h2 = 1'b0; d2 = 32'd0;
`endif
        n_vec++;
        cmp(tag, id, "ld_ready",  {31'd0, ld_ready},  {31'd0, v.e_ldr});
        cmp(tag, id, "alu_ready", {31'd0, alu_ready}, {31'd0, v.e_alr});
        cmp(tag, id, "we3",       {31'd0, we3},       {31'd0, v.e_we});
        cmp(tag, id, "wa3",       {27'd0, wa3},       {27'd0, v.e_wa});
        cmp(tag, id, "wd3",       wd3,                v.e_wd);
        cmp(tag, id, "empty",     {31'd0, empty},     {31'd0, v.e_empty});
        cmp(tag, id, "fwd1_hit",  {31'd0, fwd1_hit},  {31'd0, h1});
        cmp(tag, id, "fwd1_data", fwd1_data,          d1);
        cmp(tag, id, "fwd2_hit",  {31'd0, fwd2_hit},  {31'd0, h2});
        cmp(tag, id, "fwd2_data", fwd2_data,          d2);
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int id);
        applyStimulus(v);
        #2;
        checkOutput(v, tag, id);
        @(negedge clk);
    endtask

    initial begin
        vec_t idle;
        vec_t rv;
        n_vec    = 0;
        n_checks = 0;
        n_fail   = 0;

        //          ldv ldd    ldx        av ad     ax         dr r1     r2     ldr alr we wa     wd            emp h1 d1          h2 d2
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd0,  5'd0,  1, 1, 0, 5'd0,  32'h0,        1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 5'd5,  32'h12345678, 0, 5'd0,  32'h0,  1, 5'd5,  5'd0,  1, 1, 0, 5'd0,  32'h0,        1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd5,  5'd0,  1, 1, 1, 5'd5,  32'h12345678, 0, 1, 32'h12345678, 0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd5,  5'd0,  1, 1, 0, 5'd0,  32'h0,        1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 5'd3,  32'hA,        1, 5'd4,  32'hB,  1, 5'd0,  5'd0,  1, 1, 0, 5'd0,  32'h0,        1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd4,  5'd3,  1, 1, 1, 5'd3,  32'hA,        0, 1, 32'hB,        1, 32'hA));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd4,  5'd3,  1, 1, 1, 5'd4,  32'hB,        0, 1, 32'hB,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd0,  5'd0,  1, 1, 0, 5'd0,  32'h0,        1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd0,  32'hFF, 1, 5'd0,  5'd0,  1, 1, 0, 5'd0,  32'h0,        1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd0,  5'd0,  1, 1, 0, 5'd0,  32'h0,        1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 5'd7,  32'h11,       1, 5'd7,  32'h22, 0, 5'd0,  5'd0,  1, 1, 0, 5'd0,  32'h0,        1, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 5'd9,  32'h99,       0, 5'd0,  32'h0,  0, 5'd7,  5'd0,  1, 1, 0, 5'd7,  32'h11,       0, 1, 32'h22,       0, 32'h0));
        vecs.push_back(mk(1, 5'd10, 32'hAA,       1, 5'd11, 32'hBB, 0, 5'd0,  5'd0,  1, 0, 0, 5'd7,  32'h11,       0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd12, 32'hCC, 0, 5'd10, 5'd11, 0, 0, 0, 5'd7,  32'h11,       0, 1, 32'hAA,       0, 32'h0));
        vecs.push_back(mk(1, 5'd13, 32'hDD,       0, 5'd0,  32'h0,  1, 5'd0,  5'd0,  0, 0, 1, 5'd7,  32'h11,       0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd7,  5'd0,  1, 1, 1, 5'd7,  32'h22,       0, 1, 32'h22,       0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd0,  5'd0,  1, 1, 1, 5'd9,  32'h99,       0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(1, 5'd14, 32'hEE,       0, 5'd0,  32'h0,  1, 5'd0,  5'd0,  1, 1, 1, 5'd10, 32'hAA,       0, 0, 32'h0,        0, 32'h0));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd0,  5'd14, 1, 1, 1, 5'd14, 32'hEE,       0, 0, 32'h0,        1, 32'hEE));
        vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,  1, 5'd0,  5'd0,  1, 1, 0, 5'd0,  32'h0,        1, 0, 32'h0,        0, 32'h0));

        // After a mid-cycle reset: nothing stale may issue, then a fresh entry drains normally.
        rvecs.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 1, 5'd21, 5'd0, 1, 1, 0, 5'd0,  32'h0,  1, 0, 32'h0,  0, 32'h0));
        rvecs.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 1, 5'd21, 5'd0, 1, 1, 0, 5'd0,  32'h0,  1, 0, 32'h0,  0, 32'h0));
        rvecs.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 1, 5'd20, 5'd0, 1, 1, 0, 5'd0,  32'h0,  1, 0, 32'h0,  0, 32'h0));
        rvecs.push_back(mk(1, 5'd25, 32'h55, 0, 5'd0, 32'h0, 1, 5'd25, 5'd0, 1, 1, 0, 5'd0,  32'h0,  1, 0, 32'h0,  0, 32'h0));
        rvecs.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 1, 5'd25, 5'd0, 1, 1, 1, 5'd25, 32'h55, 0, 1, 32'h55, 0, 32'h0));
        rvecs.push_back(mk(0, 5'd0,  32'h0,  0, 5'd0, 32'h0, 1, 5'd25, 5'd0, 1, 1, 0, 5'd0,  32'h0,  1, 0, 32'h0,  0, 32'h0));

        idle = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd0, 5'd0, 1, 1, 0, 5'd0, 32'h0, 1, 0, 32'h0, 0, 32'h0);

        reset_n = 1'b0;
        applyStimulus(idle);
        #12;
        checkOutput(idle, "reset", 0);
        @(negedge clk);
        reset_n = 1'b1;

        $display("[TB] table vectors");
        foreach (vecs[i]) run_vec(vecs[i], "v", i);

        $display("[TB] async reset with three pending entries");
        applyStimulus(mk(1, 5'd20, 32'h1, 1, 5'd21, 32'h2, 0, 5'd0, 5'd0,
                         1, 1, 0, 5'd0, 32'h0, 1, 0, 32'h0, 0, 32'h0));
        @(negedge clk);
        applyStimulus(mk(1, 5'd22, 32'h3, 0, 5'd0, 32'h0, 0, 5'd0, 5'd0,
                         1, 1, 0, 5'd0, 32'h0, 1, 0, 32'h0, 0, 32'h0));
        @(negedge clk);
        rv = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd21, 5'd0,
                1, 1, 1, 5'd20, 32'h1, 0, 1, 32'h2, 0, 32'h0);
        run_vec(rv, "pre", 0);
        // One entry drained at that edge; reset now lands mid-cycle with two left.
        rv = mk(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 5'd21, 5'd0,
                1, 1, 0, 5'd0, 32'h0, 1, 0, 32'h0, 0, 32'h0);
        applyStimulus(rv);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput(rv, "rst", 0);
        @(negedge clk);
        reset_n = 1'b1;
        foreach (rvecs[i]) run_vec(rvecs[i], "r", i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
